// File: rtl/wb_ram_slave_pkg.sv
// Shared definitions for the Wishbone RAM slave.
//   state_t : response state machine encoding (idle, wait states, response).
package wb_ram_slave_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_WAIT = 2'd1,
    STATE_RESP = 2'd2
  } state_t;

endpackage : wb_ram_slave_pkg

// File: rtl/wb_ram_slave_mem.sv
// Word-organised storage for the Wishbone RAM slave.
// Byte-enable synchronous write and combinational read of the addressed word.
//   clk   : write clock, rising edge
//   we    : write strobe for the addressed word
//   addr  : word index
//   wdata : write data
//   sel   : byte enables, bit k covers byte k
//   rdata : current contents of the addressed word
module wb_ram_slave_mem #(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  localparam int SEL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [SEL_WIDTH-1:0]  sel,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_array [DEPTH];
  logic [DATA_WIDTH-1:0] merged;

  assign rdata = mem_array[addr];

  // Unselected bytes write back their current value, so one whole-word
  // write per edge implements the byte enables.
  generate
    for (genvar gi = 0; gi < SEL_WIDTH; gi++) begin : g_byte_merge
      assign merged[gi*8 +: 8] = sel[gi] ? wdata[gi*8 +: 8] : rdata[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (we) begin
      mem_array[addr] <= merged;
    end
  end

endmodule : wb_ram_slave_mem

// File: rtl/wb_ram_slave.sv
// Wishbone B4 classic (non-pipelined) RAM slave with programmable wait states.
// A request is latched in IDLE, optionally delayed WAIT_STATES cycles, then
// terminated by a one-cycle registered ack_o (in range) or err_o (out of range).
//   clk_i  : clock, rising edge          rst_i : asynchronous active-high reset
//   cyc_i  : bus cycle in progress       stb_i : slave strobe
//   we_i   : 1 = write, 0 = read         adr_i : word address
//   dat_i  : write data                  sel_i : byte enables
//   ack_o  : normal termination          err_o : error termination
//   dat_o  : read data, valid with ack_o, otherwise 0
module wb_ram_slave
  import wb_ram_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1,
  localparam int SEL_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic [SEL_WIDTH-1:0]  sel_i,
  output logic                  ack_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] dat_o
);

  localparam int CNT_WIDTH = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                state_reg, state_next;
  logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0] adr_reg, adr_next;
  logic                  we_reg, we_next;
  logic [DATA_WIDTH-1:0] dat_reg, dat_next;
  logic [SEL_WIDTH-1:0]  sel_reg, sel_next;
  logic                  ack_reg, ack_next;
  logic                  err_reg, err_next;
  logic [DATA_WIDTH-1:0] rdat_reg, rdat_next;

  logic                  req;
  logic                  go_resp;
  logic [ADDR_WIDTH-1:0] req_adr;
  logic                  req_we;
  logic [DATA_WIDTH-1:0] req_dat;
  logic [SEL_WIDTH-1:0]  req_sel;
  logic                  in_range;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign req = cyc_i & stb_i;

  // With zero wait states the response is produced on the sampling edge
  // itself, so the request fields come straight from the bus in IDLE and
  // from the latch afterwards.
  assign req_adr  = (state_reg == STATE_IDLE) ? adr_i : adr_reg;
  assign req_we   = (state_reg == STATE_IDLE) ? we_i  : we_reg;
  assign req_dat  = (state_reg == STATE_IDLE) ? dat_i : dat_reg;
  assign req_sel  = (state_reg == STATE_IDLE) ? sel_i : sel_reg;
  assign in_range = {1'b0, req_adr} < DEPTH_LIM;
  assign mem_we   = go_resp & in_range & req_we;

  wb_ram_slave_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (MEM_AW)
  ) u_mem (
    .clk   (clk_i),
    .we    (mem_we),
    .addr  (req_adr[MEM_AW-1:0]),
    .wdata (req_dat),
    .sel   (req_sel),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= STATE_IDLE;
      cnt_reg   <= '0;
      adr_reg   <= '0;
      we_reg    <= 1'b0;
      dat_reg   <= '0;
      sel_reg   <= '0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      rdat_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      adr_reg   <= adr_next;
      we_reg    <= we_next;
      dat_reg   <= dat_next;
      sel_reg   <= sel_next;
      ack_reg   <= ack_next;
      err_reg   <= err_next;
      rdat_reg  <= rdat_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    adr_next   = adr_reg;
    we_next    = we_reg;
    dat_next   = dat_reg;
    sel_next   = sel_reg;
    go_resp    = 1'b0;
    ack_next   = 1'b0;
    err_next   = 1'b0;
    rdat_next  = '0;

    case (state_reg)
      STATE_IDLE: begin
        if (req) begin
          adr_next = adr_i;
          we_next  = we_i;
          dat_next = dat_i;
          sel_next = sel_i;
          cnt_next = CNT_WIDTH'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            state_next = STATE_RESP;
            go_resp    = 1'b1;
          end else begin
            state_next = STATE_WAIT;
          end
        end
      end
      STATE_WAIT: begin
        // Abort takes priority, even on the edge that would have responded.
        if (!req) begin
          state_next = STATE_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_WIDTH'(1)) begin
          state_next = STATE_RESP;
          cnt_next   = '0;
          go_resp    = 1'b1;
        end else begin
          cnt_next = cnt_reg - CNT_WIDTH'(1);
        end
      end
      STATE_RESP: begin
        // Leaving RESP never samples the bus, so a held strobe cannot
        // restart the same transfer on this edge.
        state_next = STATE_IDLE;
      end
      default: begin
        state_next = STATE_IDLE;
      end
    endcase

    if (go_resp) begin
      ack_next = in_range;
      err_next = !in_range;
      if (in_range && !req_we) begin
        rdat_next = mem_rdata;
      end
    end
  end

  assign ack_o = ack_reg;
  assign err_o = err_reg;
  assign dat_o = rdat_reg;

endmodule : wb_ram_slave

// File: tb/tb_wb_ram_slave.sv
// Directed self-checking bench for wb_ram_slave. Three instances share the
// bus inputs: wait states 1, 3 and 0; each scenario checks only the instance
// whose timing it drives.
module tb_wb_ram_slave;

  logic        clk;
  logic        rst;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [11:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;

  logic        ack1, err1, ack3, err3, ack0, err0;
  logic [31:0] dat1, dat3, dat0;

  int n_checks = 0;
  int n_errors = 0;

  wb_ram_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr),
    .dat_i(dat), .sel_i(sel), .ack_o(ack1), .err_o(err1), .dat_o(dat1)
  );

  wb_ram_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr),
    .dat_i(dat), .sel_i(sel), .ack_o(ack3), .err_o(err3), .dat_o(dat3)
  );

  wb_ram_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr),
    .dat_i(dat), .sel_i(sel), .ack_o(ack0), .err_o(err0), .dat_o(dat0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic ack_of(input int which);
    case (which)
      0:       return ack0;
      1:       return ack1;
      default: return ack3;
    endcase
  endfunction

  function automatic logic err_of(input int which);
    case (which)
      0:       return err0;
      1:       return err1;
      default: return err3;
    endcase
  endfunction

  function automatic logic [31:0] dat_of(input int which);
    case (which)
      0:       return dat0;
      1:       return dat1;
      default: return dat3;
    endcase
  endfunction

  // One complete transfer on instance 'which' (its wait states = ws).
  // Must be called between clock edges; returns one cycle after the response
  // has dropped, again between edges.
  task automatic xfer(input int which, input int ws, input logic wr, input logic [11:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic got_ack, output logic got_err, output logic [31:0] rd);
    int edges;
    cyc = 1'b1; stb = 1'b1; we = wr; adr = a; dat = d; sel = s;
    edges = 0; got_ack = 1'b0; got_err = 1'b0;
    while (edges < 20 && !got_ack && !got_err) begin
      @(posedge clk); #1;
      edges++;
      got_ack = ack_of(which);
      got_err = err_of(which);
    end
    rd = dat_of(which);
    check("latency", edges, ws + 1);
    check("ack_err_exclusive", {31'd0, got_ack & got_err}, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("ack_drop", {31'd0, ack_of(which)}, 32'd0);
    check("err_drop", {31'd0, err_of(which)}, 32'd0);
    check("dat_drop", dat_of(which), 32'd0);
    $display("xfer dut%0d %s adr=%h dat=%h sel=%h -> ack=%0b err=%0b rdata=%h edges=%0d",
             which, wr ? "WR" : "RD", a, d, s, got_ack, got_err, rd, edges);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        a_ok, e_ok, seen;
    logic [31:0] rd;

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = '0;

    // Reset state
    #12;
    check("rst_ack", {31'd0, ack1}, 32'd0);
    check("rst_err", {31'd0, err1}, 32'd0);
    check("rst_dat", dat1, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full-word write and read, one wait state
    xfer(1, 1, 1'b1, 12'h005, 32'hDEADBEEF, 4'hF, a_ok, e_ok, rd);
    check("wr_ack", {31'd0, a_ok}, 32'd1);
    check("wr_err", {31'd0, e_ok}, 32'd0);
    xfer(1, 1, 1'b0, 12'h005, 32'h0, 4'hF, a_ok, e_ok, rd);
    check("rd_ack", {31'd0, a_ok}, 32'd1);
    check("rd_data", rd, 32'hDEADBEEF);

    // Byte enables 0x5: bytes 0 and 2 replaced
    xfer(1, 1, 1'b1, 12'h005, 32'h11223344, 4'h5, a_ok, e_ok, rd);
    check("be_wr_ack", {31'd0, a_ok}, 32'd1);
    xfer(1, 1, 1'b0, 12'h005, 32'h0, 4'h0, a_ok, e_ok, rd);
    check("be_rd_data", rd, 32'hDE22BE44);

    // sel=0 write is acked but changes nothing
    xfer(1, 1, 1'b1, 12'h005, 32'hFFFFFFFF, 4'h0, a_ok, e_ok, rd);
    check("sel0_ack", {31'd0, a_ok}, 32'd1);
    xfer(1, 1, 1'b0, 12'h005, 32'h0, 4'hF, a_ok, e_ok, rd);
    check("sel0_rd_data", rd, 32'hDE22BE44);

    // Out of range: 0x400 aliases index 0 in the low bits
    xfer(1, 1, 1'b1, 12'h000, 32'hCAFEF00D, 4'hF, a_ok, e_ok, rd);
    check("oor_pre_ack", {31'd0, a_ok}, 32'd1);
    xfer(1, 1, 1'b1, 12'h400, 32'hFFFFFFFF, 4'hF, a_ok, e_ok, rd);
    check("oor_wr_err", {31'd0, e_ok}, 32'd1);
    check("oor_wr_ack", {31'd0, a_ok}, 32'd0);
    xfer(1, 1, 1'b0, 12'h000, 32'h0, 4'hF, a_ok, e_ok, rd);
    check("oor_unchanged", rd, 32'hCAFEF00D);
    xfer(1, 1, 1'b0, 12'h405, 32'h0, 4'hF, a_ok, e_ok, rd);
    check("oor_rd_err", {31'd0, e_ok}, 32'd1);
    check("oor_rd_data", rd, 32'h0);

    // Abort with three wait states: drop cyc/stb after one wait cycle
    xfer(3, 3, 1'b1, 12'h010, 32'h12345678, 4'hF, a_ok, e_ok, rd);
    check("ab_pre_ack", {31'd0, a_ok}, 32'd1);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 12'h010; dat = 32'hFFFFFFFF; sel = 4'hF;
    @(posedge clk); #1;
    seen = ack3 | err3;
    @(posedge clk); #1;
    seen = seen | ack3 | err3;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      seen = seen | ack3 | err3;
    end
    check("abort_no_resp", {31'd0, seen}, 32'd0);
    xfer(3, 3, 1'b0, 12'h010, 32'h0, 4'hF, a_ok, e_ok, rd);
    check("abort_unmodified", rd, 32'h12345678);

    // Reset while in WAIT: write discarded, request right after release works
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 12'h005; dat = 32'h0BADC0DE; sel = 4'hF;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    #1;
    check("rstw_ack", {31'd0, ack1}, 32'd0);
    check("rstw_err", {31'd0, err1}, 32'd0);
    check("rstw_dat", dat1, 32'd0);
    #8 rst = 1'b0;
    xfer(1, 1, 1'b0, 12'h005, 32'h0, 4'hF, a_ok, e_ok, rd);
    check("rstw_after_ack", {31'd0, a_ok}, 32'd1);
    check("rstw_discarded", rd, 32'hDE22BE44);

    // Reset while the read response is on the bus clears it immediately
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 12'h005; sel = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstr_pre_ack", {31'd0, ack1}, 32'd1);
    check("rstr_pre_dat", dat1, 32'hDE22BE44);
    #2 rst = 1'b1;
    cyc = 1'b0; stb = 1'b0;
    #1;
    check("rstr_ack", {31'd0, ack1}, 32'd0);
    check("rstr_dat", dat1, 32'd0);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    // Zero wait states: back-to-back reads with strobe held
    xfer(0, 0, 1'b1, 12'h001, 32'hA5A5A5A5, 4'hF, a_ok, e_ok, rd);
    check("b2b_pre_ack", {31'd0, a_ok}, 32'd1);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 12'h001; sel = 4'h0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("b2b_ack", {31'd0, ack0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("b2b_dat", dat0, (i % 2 == 0) ? 32'hA5A5A5A5 : 32'd0);
      check("b2b_err", {31'd0, err0}, 32'd0);
      $display("b2b cycle %0d ack=%0b dat=%h", i, ack0, dat0);
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_wb_ram_slave

// File: doc/wb_ram_slave.md
WB_RAM_SLAVE -- requirements
Module: wb_ram_slave

Interface
REQ-001 Parameters SHALL be as follows, one per line (name, default, meaning):
- ADDR_WIDTH, 12, word-address width of adr_i.
- DATA_WIDTH, 32, data bus width, multiple of 8.
- DEPTH, 1024, number of words implemented, at most 2**ADDR_WIDTH.
- WAIT_STATES, 1, extra cycles inserted before the response, 0..15.
REQ-002 SEL_WIDTH SHALL be a localparam equal to DATA_WIDTH/8.
REQ-003 Ports SHALL be as follows, one per line (name, direction, width, meaning):
- clk_i, in, 1, sole clock, rising edge.
- rst_i, in, 1, reset, asynchronous, active-high.
- cyc_i, in, 1, bus cycle in progress.
- stb_i, in, 1, strobe, this slave is selected.
- we_i, in, 1, 1 = write, 0 = read.
- adr_i, in, ADDR_WIDTH, word address.
- dat_i, in, DATA_WIDTH, write data.
- sel_i, in, SEL_WIDTH, byte enables; bit k covers byte k.
- ack_o, out, 1, normal termination.
- err_o, out, 1, error termination.
- dat_o, out, DATA_WIDTH, read data.

Function
REQ-004 The block SHALL be a Wishbone B4 classic, non-pipelined slave whose ack_o, err_o and dat_o are all registered.
REQ-005 The state machine SHALL have states IDLE, WAIT and RESP.
REQ-006 In IDLE, when cyc_i&stb_i=1 at an edge, the block SHALL latch adr_i/we_i/dat_i/sel_i, load the wait counter with WAIT_STATES, and go to WAIT (or straight to RESP if WAIT_STATES=0).
REQ-007 In WAIT, the counter SHALL decrement each edge; the block SHALL enter RESP at the edge where the counter equals 1.
REQ-008 The response SHALL appear exactly WAIT_STATES+1 cycles after the sampling edge, be high for exactly one cycle, and drop at the following edge, returning to IDLE.
REQ-009 No request SHALL be sampled on the edge that leaves RESP, so back-to-back transfers complete every WAIT_STATES+2 cycles.
REQ-010 A latched address below DEPTH SHALL produce ack_o=1 and err_o=0; an address at or above DEPTH SHALL produce err_o=1, ack_o=0, no write, and dat_o=0.
REQ-011 A write SHALL update only the bytes whose sel_i bit is 1, on the edge that asserts ack_o.
REQ-012 A write with sel_i=0 SHALL still be acked and SHALL modify nothing.
REQ-013 A read SHALL load the full stored word into dat_o on the edge that asserts ack_o, regardless of sel_i.
REQ-014 dat_o SHALL return to 0 on the edge that deasserts ack_o.
REQ-015 A read of an address never written SHALL return an undefined word; the bench SHALL ignore it.
REQ-016 If cyc_i or stb_i is low at any edge while in WAIT, the block SHALL abort: go to IDLE, no write, no ack_o/err_o pulse.
REQ-017 ack_o and err_o SHALL never be high simultaneously.
REQ-018 Inputs SHALL be ignored outside IDLE except for the abort check in REQ-016.
REQ-019 The wait counter SHALL be $clog2(WAIT_STATES+1) bits wide, minimum 1 bit.

Reset
REQ-020 rst_i high SHALL immediately (asynchronously) force state to IDLE, counter to 0, ack_o=0, err_o=0 and dat_o=0.
REQ-021 Memory contents SHALL NOT be reset.
REQ-022 A reset during WAIT or RESP SHALL discard the transfer; a write SHALL not occur unless its ack edge preceded the reset.
REQ-023 After rst_i falls, the first request SHALL be sampled at the next rising edge.

Structure
REQ-024 A package wb_ram_slave_pkg SHALL hold the state enum (STATE_IDLE, STATE_WAIT, STATE_RESP).
REQ-025 Storage SHALL be one sub-module, wb_ram_slave_mem: a DEPTH x DATA_WIDTH array with byte-enable synchronous write and combinational read.
REQ-026 The top level SHALL contain the FSM, counter, request latch, range check and output registers.

Verification
REQ-027 The bench SHALL cover at least these scenarios:
- WAIT_STATES=1: write adr 0x005, dat 0xDEADBEEF, sel 0xF -> ack_o high in the 2nd cycle after the sampling edge for 1 cycle; read adr 0x005 -> dat_o=0xDEADBEEF with ack_o.
- Byte enables: after 0xDEADBEEF, write 0x11223344 with sel 0x5 -> read returns 0xDE22BE44.
- Out of range (DEPTH=1024): write adr 0x400 -> err_o pulse, ack_o=0; then read adr 0x000 -> unchanged prior value.
- Abort: WAIT_STATES=3, drop cyc_i after 1 wait cycle -> no ack_o/err_o; the target word is unmodified.
- Reset mid-transfer: assert rst_i asynchronously in WAIT -> ack_o, err_o and dat_o are 0 immediately; a new request after release completes normally.
- WAIT_STATES=0: back-to-back reads with stb held -> ack_o pulses every 2 cycles, never two consecutive cycles high.
